ign_sched_multi: RTL and testbench

//  NCH-channel angle-to-time spark scheduler; sits between crank decoder and coil drivers.
//  On each tooth strobe, scans channels one per cycle and arms each channel whose timing

---
 rtl/ign_sched_multi.sv | 201 ++++++++++++++++++++
 tb/tb_ign_sched_multi.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ign_sched_multi.sv
// Multi-channel angle-to-time spark scheduler: one channel evaluated per cycle after a tooth strobe.
// Optional build macro DWELL_EN replaces the fixed fire pulse with a per-channel coil charge (dwell).
module ign_sched_multi #(
  parameter int NCH        = 4,
  parameter int ANG_W      = 16,
  parameter int PER_W      = 32,
  parameter int FRAC_SHIFT = 7,
  parameter int PULSE_W    = 1,
  parameter int DW_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   trigger,
  input  logic [ANG_W-1:0]       eng_phase,
  input  logic [ANG_W-1:0]       next_tooth_width,
  input  logic [PER_W-1:0]       tooth_period,
  input  logic [NCH*ANG_W-1:0]   timing,
  input  logic [NCH-1:0]         ch_en,
`ifdef DWELL_EN
  input  logic [NCH*DW_W-1:0]    dwell,
`endif
  output logic [NCH-1:0]         out,
  output logic [NCH-1:0]         busy,
  output logic [NCH-1:0]         missed,
  output logic                   scan_ovf
);

  localparam int IDX_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PROD_W = PER_W + ANG_W;
  localparam int WIN_W  = ANG_W + 2;

  typedef enum logic {S_IDLE, S_SCAN} scan_state_t;
  typedef enum logic [1:0] {CH_IDLE, CH_ARMED, CH_FIRE} ch_state_t;

  scan_state_t        sc_q, sc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ANG_W-1:0]   ph_q, ph_d, width_q, width_d;
  logic [PER_W-1:0]   per_q, per_d;
  logic               ovf_pend_q, ovf_pend_d, scan_ovf_q;

  ch_state_t          ch_q [NCH];
  ch_state_t          ch_d [NCH];
  logic [PER_W-1:0]   cnt_q [NCH];
  logic [PER_W-1:0]   cnt_d [NCH];
  logic [NCH-1:0]     out_q, out_d, miss_pend_q, miss_pend_d, missed_q;

  // Scanner: snapshot tooth data, then walk channel slots one per cycle
  always_comb begin
    sc_d       = sc_q;
    idx_d      = idx_q;
    ph_d       = ph_q;
    width_d    = width_q;
    per_d      = per_q;
    ovf_pend_d = 1'b0;
    case (sc_q)
      S_IDLE: begin
        if (trigger) begin
          sc_d    = S_SCAN;
          idx_d   = '0;
          ph_d    = eng_phase;
          width_d = next_tooth_width;
          per_d   = tooth_period;
        end
      end
      S_SCAN: begin
        ovf_pend_d = trigger;
        if (idx_q == IDX_W'(NCH - 1)) sc_d = S_IDLE;
        else                          idx_d = idx_q + 1'b1;
      end
      default: sc_d = S_IDLE;
    endcase
  end

  // Slot evaluation for the channel currently under the scan index
  logic [ANG_W-1:0]  tim_sel, diff;
  logic [WIN_W-1:0]  win_lo, win_hi, tim_ext;
  logic              hit;
  logic [PROD_W-1:0] prod, delay, lead;
  logic [PER_W-1:0]  load;

  always_comb begin
    tim_sel = timing[idx_q*ANG_W +: ANG_W];
    tim_ext = WIN_W'(tim_sel);
    win_lo  = WIN_W'(ph_q);
    win_hi  = WIN_W'(ph_q) + WIN_W'(width_q) + WIN_W'(2);
    hit     = (sc_q == S_SCAN) && ch_en[idx_q] && (tim_ext > win_lo) && (tim_ext <= win_hi);
    diff    = tim_sel - ph_q;
    prod    = PROD_W'(per_q) * PROD_W'(diff);
    delay   = prod >> FRAC_SHIFT;
    // Load is offset by the slot latency so the output edge lands at T+delay
`ifdef DWELL_EN
    lead    = PROD_W'(idx_q) + PROD_W'(2) + PROD_W'(dwell[idx_q*DW_W +: DW_W]);
`else
    lead    = PROD_W'(idx_q) + PROD_W'(2);
`endif
    load    = (delay > lead) ? PER_W'(delay - lead) : '0;
  end

  // Per-channel FSM; FIRE doubles as CHARGE in the dwell build
  logic [PER_W-1:0] hold_m1;
`ifdef DWELL_EN
  logic [DW_W-1:0]  dw_k;
`endif

  always_comb begin
    hold_m1 = '0;
`ifdef DWELL_EN
    dw_k    = '0;
`endif
    for (int unsigned k = 0; k < NCH; k++) begin
      ch_d[k]        = ch_q[k];
      cnt_d[k]       = cnt_q[k];
      out_d[k]       = out_q[k];
      miss_pend_d[k] = 1'b0;
`ifdef DWELL_EN
      dw_k    = dwell[k*DW_W +: DW_W];
      hold_m1 = (dw_k == '0) ? '0 : PER_W'(dw_k - 1'b1);
`else
      hold_m1 = PER_W'(PULSE_W - 1);
`endif
      case (ch_q[k])
        CH_ARMED: begin
          if (!ch_en[k]) begin
            ch_d[k]  = CH_IDLE;
            out_d[k] = 1'b0;
          end else if (cnt_q[k] == '0) begin
            ch_d[k]  = CH_FIRE;
            out_d[k] = 1'b1;
            cnt_d[k] = hold_m1;
          end else begin
            cnt_d[k] = cnt_q[k] - 1'b1;
          end
        end
        CH_FIRE: begin
          if (!ch_en[k] || cnt_q[k] == '0) begin
            ch_d[k]  = CH_IDLE;
            out_d[k] = 1'b0;
          end else begin
            cnt_d[k] = cnt_q[k] - 1'b1;
          end
        end
        default: begin
          ch_d[k]  = CH_IDLE;
          out_d[k] = 1'b0;
        end
      endcase
      // Arming checks the post-transition state so a channel finishing this edge can re-arm
      if (hit && idx_q == IDX_W'(k)) begin
        if (ch_d[k] == CH_IDLE) begin
          ch_d[k]  = CH_ARMED;
          cnt_d[k] = load;
        end else begin
          miss_pend_d[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_q        <= S_IDLE;
      idx_q       <= '0;
      ph_q        <= '0;
      width_q     <= '0;
      per_q       <= '0;
      ovf_pend_q  <= 1'b0;
      scan_ovf_q  <= 1'b0;
      out_q       <= '0;
      miss_pend_q <= '0;
      missed_q    <= '0;
      for (int unsigned k = 0; k < NCH; k++) begin
        ch_q[k]  <= CH_IDLE;
        cnt_q[k] <= '0;
      end
    end else begin
      sc_q        <= sc_d;
      idx_q       <= idx_d;
      ph_q        <= ph_d;
      width_q     <= width_d;
      per_q       <= per_d;
      ovf_pend_q  <= ovf_pend_d;
      scan_ovf_q  <= ovf_pend_q;
      out_q       <= out_d;
      miss_pend_q <= miss_pend_d;
      missed_q    <= miss_pend_q;
      for (int unsigned k = 0; k < NCH; k++) begin
        ch_q[k]  <= ch_d[k];
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NCH; k++) busy[k] = (ch_q[k] != CH_IDLE);
  end

  assign out      = out_q;
  assign missed   = missed_q;
  assign scan_ovf = scan_ovf_q;

endmodule

// File: tb/tb_ign_sched_multi.sv
// Bench for ign_sched_multi: vector table, hand-written corner sequences and a randomized run
// against an absolute-time reference model.
module tb_ign_sched_multi;
  localparam int NCH = 4, ANG_W = 16, PER_W = 32, FS = 7, PW = 1;

  logic             clk = 1'b0, rst_n = 1'b0, trigger = 1'b0;
  logic [15:0]      eng_phase = '0, next_tooth_width = '0;
  logic [31:0]      tooth_period = '0;
  logic [63:0]      timing = '0;
  logic [3:0]       ch_en = '0;
`ifdef DWELL_EN
  logic [63:0]      dwell = '0;
`endif
  logic [3:0]       out, busy, missed;
  logic             scan_ovf;

  ign_sched_multi #(.NCH(NCH), .ANG_W(ANG_W), .PER_W(PER_W), .FRAC_SHIFT(FS), .PULSE_W(PW), .DW_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .eng_phase(eng_phase),
    .next_tooth_width(next_tooth_width), .tooth_period(tooth_period), .timing(timing),
    .ch_en(ch_en),
`ifdef DWELL_EN
    .dwell(dwell),
`endif
    .out(out), .busy(busy), .missed(missed), .scan_ovf(scan_ovf));

  always #5 clk = ~clk;

  int     checks = 0, errors = 0;
  longint n = 0;
  bit     chk_model = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (edge %0d)", name, act, exp, n);
    end
  endtask

  // Reference model: every arm is tracked as absolute edge numbers (arm, fire, end)
  bit     m_act [NCH];
  longint m_arm [NCH], m_fire [NCH], m_end [NCH];
  bit     sc_act;
  longint sc_T, sn_ph, sn_w, sn_per;
  logic [3:0] miss_next, exp_missed, exp_out, exp_busy;
  logic       ovf_next, exp_ovf;

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_act[k] = 0; m_arm[k] = 0; m_fire[k] = 0; m_end[k] = 0;
    end
    sc_act = 0; sc_T = 0; sn_ph = 0; sn_w = 0; sn_per = 0;
    miss_next = '0; exp_missed = '0; exp_out = '0; exp_busy = '0;
    ovf_next = 0; exp_ovf = 0;
  endtask

  task automatic model_edge();
    longint t, d;
    int k;
    exp_missed = miss_next; exp_ovf = ovf_next;
    miss_next = '0; ovf_next = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NCH; c++)
      if (m_act[c] && m_arm[c] < n && n <= m_end[c] && !ch_en[c]) m_act[c] = 0;
    if (sc_act) begin
      k = int'(n - sc_T - 1);
      if (trigger) ovf_next = 1;
      t = longint'(timing[k*16 +: 16]);
      if (ch_en[k] && t > sn_ph && t <= sn_ph + sn_w + 2) begin
        if (m_act[k] && m_arm[k] <= n - 1 && n <= m_end[k]) miss_next[k] = 1'b1;
        else begin
          d = (sn_per * (t - sn_ph)) / (longint'(1) << FS);
          m_act[k]  = 1;
          m_arm[k]  = n;
          m_fire[k] = sc_T + ((d > k + 2) ? d : longint'(k + 2));
          m_end[k]  = m_fire[k] + PW - 1;
        end
      end
      if (k == NCH - 1) sc_act = 0;
    end else if (trigger) begin
      sc_act = 1; sc_T = n;
      sn_ph = eng_phase; sn_w = next_tooth_width; sn_per = tooth_period;
    end
    for (int c = 0; c < NCH; c++) begin
      exp_busy[c] = m_act[c] && m_arm[c] <= n && n <= m_end[c];
      exp_out[c]  = m_act[c] && m_fire[c] <= n && n <= m_end[c];
    end
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    model_edge();
    @(negedge clk);
    if (chk_model) begin
      chk("rand_out", out, exp_out);
      chk("rand_busy", busy, exp_busy);
      chk("rand_missed", missed, exp_missed);
      chk("rand_scan_ovf", scan_ovf, exp_ovf);
    end
  endtask

  task automatic setup1();
    eng_phase = 16'd100; next_tooth_width = 16'd30; tooth_period = 32'd256;
    timing = {16'd101, 16'd133, 16'd110, 16'd110};
    ch_en = 4'hF;
  endtask

  typedef struct {
    logic [15:0]      ph, w;
    logic [31:0]      per;
    logic [3:0][15:0] t;
    logic [3:0]       en;
    logic [3:0][7:0]  rise;   // 8'hFF: channel must not fire
  } vec_t;

  function automatic vec_t mk(input int ph, input int w, input int per,
                              input logic [15:0] t0, t1, t2, t3, input logic [3:0] en,
                              input logic [7:0] r0, r1, r2, r3);
    vec_t v;
    v.ph = 16'(ph); v.w = 16'(w); v.per = 32'(per);
    v.t[0] = t0; v.t[1] = t1; v.t[2] = t2; v.t[3] = t3;
    v.en = en;
    v.rise[0] = r0; v.rise[1] = r1; v.rise[2] = r2; v.rise[3] = r3;
    return v;
  endfunction

  vec_t vecs [5];

  initial begin
    longint T;
    int rise [NCH], hi [NCH], bfirst [NCH], blast [NCH];
    int er;
    bit seen;

    vecs[0] = mk(100, 30, 256, 110, 110, 133, 101, 4'hF, 20, 20, 8'hFF, 5);
    vecs[1] = mk(100, 30, 256, 100, 132, 120, 105, 4'hF, 8'hFF, 64, 40, 10);
    vecs[2] = mk(100, 30, 256, 110, 110, 110, 110, 4'b0101, 20, 8'hFF, 20, 8'hFF);
    vecs[3] = mk(1000, 10, 128, 1001, 1005, 1012, 1013, 4'hF, 2, 5, 12, 8'hFF);
    vecs[4] = mk(65530, 10, 256, 65535, 65531, 0, 65533, 4'hF, 10, 3, 8'hFF, 6);

    model_reset();
    setup1();
    repeat (3) step();
    chk("rst_out", out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_missed", missed, 0);
    chk("rst_scan_ovf", scan_ovf, 0);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      eng_phase = vecs[i].ph; next_tooth_width = vecs[i].w; tooth_period = vecs[i].per;
      timing = vecs[i].t; ch_en = vecs[i].en;
      for (int k = 0; k < NCH; k++) begin
        rise[k] = -1; hi[k] = 0; bfirst[k] = -1; blast[k] = -1;
      end
      trigger = 1'b1; step(); T = n; trigger = 1'b0;
      repeat (90) begin
        step();
        for (int k = 0; k < NCH; k++) begin
          if (out[k]) begin
            if (rise[k] < 0) rise[k] = int'(n - T);
            hi[k]++;
          end
          if (busy[k]) begin
            if (bfirst[k] < 0) bfirst[k] = int'(n - T);
            blast[k] = int'(n - T);
          end
        end
      end
      for (int k = 0; k < NCH; k++) begin
        er = (vecs[i].rise[k] == 8'hFF) ? -1 : int'(vecs[i].rise[k]);
        chk($sformatf("vec%0d_ch%0d_rise", i, k), rise[k], er);
        chk($sformatf("vec%0d_ch%0d_width", i, k), hi[k], (er < 0) ? 0 : PW);
        chk($sformatf("vec%0d_ch%0d_busy_first", i, k), bfirst[k], (er < 0) ? -1 : k + 1);
        chk($sformatf("vec%0d_ch%0d_busy_last", i, k), blast[k], (er < 0) ? -1 : er + PW - 1);
      end
    end

    // Trigger during scan -> single scan_ovf pulse two edges later
    setup1();
    trigger = 1'b1; step(); T = n; trigger = 1'b0;
    step();
    trigger = 1'b1; step(); trigger = 1'b0;
    chk("ovf_T2", scan_ovf, 0);
    step(); chk("ovf_T3", scan_ovf, 1);
    step(); chk("ovf_T4", scan_ovf, 0);
    repeat (80) step();

    // Re-trigger while ch0/ch1 are armed
    trigger = 1'b1; step(); T = n; trigger = 1'b0;
    while (n < T + 9) step();
    trigger = 1'b1; step(); trigger = 1'b0;
    step(); chk("miss_T11", missed, 4'b0000);
    step(); chk("miss_T12", missed, 4'b0001);
    step(); chk("miss_T13", missed, 4'b0010);
    step(); chk("miss_T14", missed, 4'b0000);
    while (n < T + 19) step();
    chk("miss_out0_T19", out[0], 0);
    step(); chk("miss_out0_T20", out[0], 1);
    step(); chk("miss_out0_T21", out[0], 0);
    repeat (80) step();

    // Abort ch0 at T+8
    trigger = 1'b1; step(); T = n; trigger = 1'b0;
    while (n < T + 7) step();
    ch_en = 4'b1110;
    step(); chk("abort_busy0_T8", busy[0], 0);
    seen = 0; rise[1] = -1;
    while (n < T + 30) begin
      step();
      if (out[0] || missed != 0) seen = 1;
      if (out[1] && rise[1] < 0) rise[1] = int'(n - T);
    end
    chk("abort_out0_quiet", seen, 0);
    chk("abort_ch1_rise", rise[1], 20);
    ch_en = 4'hF;
    repeat (60) step();

    // Asynchronous reset mid-cycle at T+15
    trigger = 1'b1; step(); T = n; trigger = 1'b0;
    while (n < T + 14) step();
    chk("pre_rst_busy", busy, 4'b0011);
    @(posedge clk); n++;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", out, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_missed", missed, 0);
    chk("async_rst_ovf", scan_ovf, 0);
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    step();

    // Randomized run against the reference model
    chk_model = 1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 8) begin
        trigger = 1'b1;
        eng_phase = 16'($urandom);
        next_tooth_width = 16'($urandom_range(0, 40));
        tooth_period = 32'($urandom_range(32, 400));
        for (int k = 0; k < NCH; k++)
          timing[k*16 +: 16] = 16'(eng_phase + 16'($urandom_range(0, int'(next_tooth_width) + 4)) - 16'd1);
      end else begin
        trigger = 1'b0;
        if ($urandom_range(0, 99) < 5) begin
          int k;
          k = int'($urandom_range(0, NCH - 1));
          timing[k*16 +: 16] = 16'(eng_phase + 16'($urandom_range(0, int'(next_tooth_width) + 4)) - 16'd1);
        end
      end
      for (int k = 0; k < NCH; k++) begin
        if (ch_en[k] && $urandom_range(0, 99) < 2) ch_en[k] = 1'b0;
        else if (!ch_en[k] && $urandom_range(0, 99) < 20) ch_en[k] = 1'b1;
      end
      step();
    end
    trigger = 1'b0;
    repeat (200) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
